iir_decim_out: RTL and testbench

Output stage placed directly downstream of iir_N. It consumes the filter output y on a sample strobe and decimates by 2^LOG2_DEC using a boxcar average. The average is rounded and saturated to OUT_WIDTH, then buffered in a small first-word-fall-through (FWFT) FIFO. A valid/ready interface feeds the sink (DAC/serializer). The filter runs freely, so there is no upstream backpressure.

---
 rtl/iir_pkg.sv | 48 ++++
 rtl/iir_decim_out_fifo.sv | 64 ++++++
 rtl/iir_decim_out.sv | 109 ++++++++++
 tb/tb_iir_decim_out.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared widths, output limits and the round/saturate helper for the iir family
package iir_pkg;

   localparam int DEF_BITWIDTH   = 32;
   localparam int DEF_OUT_WIDTH  = 16;
   localparam int DEF_LOG2_DEC   = 2;
   localparam int DEF_FIFO_DEPTH = 4;

   localparam int ACC_W = DEF_BITWIDTH + DEF_LOG2_DEC;
   localparam int LVL_W = $clog2(DEF_FIFO_DEPTH + 1);

   localparam logic signed [DEF_OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(DEF_OUT_WIDTH-1){1'b1}}};
   localparam logic signed [DEF_OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(DEF_OUT_WIDTH-1){1'b0}}};

   typedef struct packed {
      logic               sat;
      logic signed [63:0] val;
   } sat_res_t;

   // Round half up toward +inf then clamp to a signed out_w range; 64 bits
   // keeps the rounding add free of intermediate truncation for any accumulator.
   function automatic sat_res_t sat_round(input logic signed [63:0] sum,
                                          input int unsigned        s,
                                          input int unsigned        out_w);
      sat_res_t           res;
      logic signed [63:0] r;
      logic signed [63:0] mx;
      logic signed [63:0] mn;
      if (s > 0) begin
         r = (sum + (64'sd1 <<< (s - 1))) >>> s;
      end else begin
         r = sum;
      end
      mx = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      mn = -(64'sd1 <<< (out_w - 1));
      res.sat = 1'b0;
      res.val = r;
      if (r > mx) begin
         res.sat = 1'b1;
         res.val = mx;
      end else if (r < mn) begin
         res.sat = 1'b1;
         res.val = mn;
      end
      return res;
   endfunction

endpackage

// File: rtl/iir_decim_out_fifo.sv
// rtl/iir_decim_out_fifo.sv - first-word-fall-through FIFO with occupancy count
module sync_fifo_fwft #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           wr_en,
   input  logic [WIDTH-1:0]               wr_data,
   input  logic                           rd_en,
   output logic [WIDTH-1:0]               rd_data,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             do_rd, do_wr;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rd_data = mem_q[rd_ptr_q];

   // A write into a full FIFO is only taken when a pop frees the head slot.
   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_wr && !do_rd) begin
         level_d = level_q + LW'(1);
      end else if (do_rd && !do_wr) begin
         level_d = level_q - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/iir_decim_out.sv
// rtl/iir_decim_out.sv - boxcar decimator with round/saturate, stage register and FWFT output FIFO
module iir_decim_out
   import iir_pkg::*;
#(
   parameter int BITWIDTH   = 32,
   parameter int OUT_WIDTH  = 16,
   parameter int LOG2_DEC   = 2,
   parameter int OUT_SHIFT  = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   input  logic signed [BITWIDTH-1:0]           y,
   output logic signed [OUT_WIDTH-1:0]          out_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level,
   output logic                                 sat,
   output logic                                 drop
);

   localparam int          AW    = BITWIDTH + LOG2_DEC;
   localparam int          CNT_W = (LOG2_DEC > 0) ? LOG2_DEC : 1;
   localparam int unsigned S     = LOG2_DEC + OUT_SHIFT;

   logic signed [AW-1:0]        acc_q, acc_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        stg_v_q, stg_v_d;
   logic                        stg_sat_q, stg_sat_d;
   logic signed [OUT_WIDTH-1:0] stg_data_q, stg_data_d;
   logic signed [OUT_WIDTH-1:0] hold_q, hold_d;
   logic signed [AW-1:0]        sum;
   logic                        last;
   sat_res_t                    res;
   logic                        unused_res_bits;

   logic [OUT_WIDTH-1:0]        head;
   logic                        fifo_full, fifo_empty, pop, push;

   assign last            = (cnt_q == CNT_W'((1 << LOG2_DEC) - 1));
   assign sum             = acc_q + AW'(y);
   assign res             = sat_round(64'(sum), S, OUT_WIDTH);
   assign unused_res_bits = ^res.val[63:OUT_WIDTH];

   always_comb begin
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      stg_v_d    = 1'b0;
      stg_sat_d  = stg_sat_q;
      stg_data_d = stg_data_q;
      if (in_valid) begin
         if (last) begin
            acc_d      = '0;
            cnt_d      = '0;
            stg_v_d    = 1'b1;
            stg_sat_d  = res.sat;
            stg_data_d = res.val[OUT_WIDTH-1:0];
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Stage result enters the FIFO one cycle later; full without a pop discards it.
   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign push      = stg_v_q && (!fifo_full || pop);
   assign sat       = stg_v_q && stg_sat_q;
   assign drop      = stg_v_q && fifo_full && !pop;

   assign hold_d   = pop ? $signed(head) : hold_q;
   assign out_data = out_valid ? $signed(head) : hold_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q      <= '0;
         cnt_q      <= '0;
         stg_v_q    <= 1'b0;
         stg_sat_q  <= 1'b0;
         stg_data_q <= '0;
         hold_q     <= '0;
      end else begin
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         stg_v_q    <= stg_v_d;
         stg_sat_q  <= stg_sat_d;
         stg_data_q <= stg_data_d;
         hold_q     <= hold_d;
      end
   end

   sync_fifo_fwft #(
      .WIDTH (OUT_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (stg_data_q),
      .rd_en   (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

endmodule

// File: tb/tb_iir_decim_out.sv
// tb/tb_iir_decim_out.sv - directed self-checking bench for iir_decim_out
module tb_iir_decim_out;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic signed [31:0] y = '0;
   logic signed [15:0] out_data;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic [2:0]         fifo_level;
   logic               sat;
   logic               drop;

   int n_checks = 0;
   int n_fail   = 0;

   always #10 clk = ~clk;

   iir_decim_out dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .y          (y),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .fifo_level (fifo_level),
      .sat        (sat),
      .drop       (drop)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic signed [31:0] v);
      in_valid = 1'b1;
      y        = v;
      tick();
      in_valid = 1'b0;
   endtask

   // Returns in cycle t+1 of the fourth strobe (stage register valid).
   task automatic feed4(input logic signed [31:0] a, input logic signed [31:0] b,
                        input logic signed [31:0] c, input logic signed [31:0] d);
      strobe(a); tick(); tick();
      strobe(b); tick(); tick();
      strobe(c); tick(); tick();
      strobe(d);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(); tick();
      n_checks++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid got %0b want 0", out_valid); end
      n_checks++; if (fifo_level !== 3'd0)  begin n_fail++; $display("FAIL reset_level got %0d want 0", fifo_level); end
      n_checks++; if (sat !== 1'b0)         begin n_fail++; $display("FAIL reset_sat got %0b want 0", sat); end
      n_checks++; if (drop !== 1'b0)        begin n_fail++; $display("FAIL reset_drop got %0b want 0", drop); end
      n_checks++; if (out_data !== 16'sd0)  begin n_fail++; $display("FAIL reset_data got %0d want 0", out_data); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_average;
      feed4(100, 200, 300, 400);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL avg_valid_t1 got %0b want 0", out_valid); end
      n_checks++; if (sat !== 1'b0)       begin n_fail++; $display("FAIL avg_sat got %0b want 0", sat); end
      tick();
      n_checks++; if (out_valid !== 1'b1)    begin n_fail++; $display("FAIL avg_valid_t2 got %0b want 1", out_valid); end
      n_checks++; if (out_data !== 16'sd250) begin n_fail++; $display("FAIL avg_data got %0d want 250", out_data); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL avg_popped got %0b want 0", out_valid); end
   endtask

   task automatic test_rounding;
      feed4(-1, -1, -1, -2);
      tick();
      n_checks++; if (out_data !== -16'sd1) begin n_fail++; $display("FAIL round_neg got %0d want -1", out_data); end
      tick();
      feed4(1, 1, 1, 2);
      tick();
      n_checks++; if (out_data !== 16'sd1) begin n_fail++; $display("FAIL round_pos got %0d want 1", out_data); end
      tick();
   endtask

   task automatic test_saturate;
      feed4(100000, 100000, 100000, 100000);
      n_checks++; if (sat !== 1'b1) begin n_fail++; $display("FAIL sat_hi_pulse got %0b want 1", sat); end
      tick();
      n_checks++; if (sat !== 1'b0)           begin n_fail++; $display("FAIL sat_hi_clear got %0b want 0", sat); end
      n_checks++; if (out_data !== 16'sd32767) begin n_fail++; $display("FAIL sat_hi_data got %0d want 32767", out_data); end
      tick();
      feed4(-100000, -100000, -100000, -100000);
      n_checks++; if (sat !== 1'b1) begin n_fail++; $display("FAIL sat_lo_pulse got %0b want 1", sat); end
      tick();
      n_checks++; if (out_data !== -16'sd32768) begin n_fail++; $display("FAIL sat_lo_data got %0d want -32768", out_data); end
      tick();
      feed4(0, 0, 0, 0);
      n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL sat_zero_pulse got %0b want 0", sat); end
      tick();
      n_checks++; if (out_data !== 16'sd0) begin n_fail++; $display("FAIL sat_zero_data got %0d want 0", out_data); end
      tick();
   endtask

   task automatic test_overflow_drop;
      out_ready = 1'b0;
      for (int g = 1; g <= 4; g++) begin
         feed4(10 * g, 10 * g, 10 * g, 10 * g);
         tick();
      end
      n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level got %0d want 4", fifo_level); end
      feed4(50, 50, 50, 50);
      n_checks++; if (drop !== 1'b1) begin n_fail++; $display("FAIL ovf_drop got %0b want 1", drop); end
      tick();
      n_checks++; if (drop !== 1'b0)       begin n_fail++; $display("FAIL ovf_drop_clear got %0b want 0", drop); end
      n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level_after got %0d want 4", fifo_level); end
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         n_checks++; if (out_data !== 16'(10 * i)) begin n_fail++; $display("FAIL ovf_pop%0d got %0d want %0d", i, out_data, 10 * i); end
         n_checks++; if (fifo_level !== 3'(5 - i)) begin n_fail++; $display("FAIL ovf_lvl%0d got %0d want %0d", i, fifo_level, 5 - i); end
         tick();
      end
      n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL ovf_empty_level got %0d want 0", fifo_level); end
      n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL ovf_empty_valid got %0b want 0", out_valid); end
   endtask

   task automatic test_full_push_pop;
      out_ready = 1'b0;
      for (int g = 1; g <= 4; g++) begin
         feed4(g, g, g, g);
         tick();
      end
      feed4(5, 5, 5, 5);
      out_ready = 1'b1;
      #1;
      n_checks++; if (drop !== 1'b0)       begin n_fail++; $display("FAIL fpp_drop got %0b want 0", drop); end
      n_checks++; if (out_data !== 16'sd1) begin n_fail++; $display("FAIL fpp_head got %0d want 1", out_data); end
      tick();
      out_ready = 1'b0;
      n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL fpp_level got %0d want 4", fifo_level); end
      out_ready = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         n_checks++; if (out_data !== 16'(i)) begin n_fail++; $display("FAIL fpp_order%0d got %0d want %0d", i, out_data, i); end
         tick();
      end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_drained got %0b want 0", out_valid); end
   endtask

   task automatic test_reset_mid_group;
      out_ready = 1'b0;
      feed4(7, 7, 7, 7);
      tick();
      strobe(1000); tick(); tick();
      strobe(1000);
      rst = 1'b1;
      tick();
      n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL rmid_valid got %0b want 0", out_valid); end
      n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rmid_level got %0d want 0", fifo_level); end
      n_checks++; if (out_data !== 16'sd0) begin n_fail++; $display("FAIL rmid_data got %0d want 0", out_data); end
      rst = 1'b0;
      out_ready = 1'b1;
      tick();
      feed4(8, 8, 8, 8);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_early got %0b want 0", out_valid); end
      tick();
      n_checks++; if (out_data !== 16'sd8)  begin n_fail++; $display("FAIL rmid_out got %0d want 8", out_data); end
      n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL rmid_lvl got %0d want 1", fifo_level); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_single got %0b want 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_average();
      test_rounding();
      test_saturate();
      test_overflow_drop();
      test_full_push_pop();
      test_reset_mid_group();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
